// File: rtl/led_fade_if.sv
// -----------------------------------------------------------------------------
// led_fade_if
//   Bundles the LED request/brightness inputs and the PWM pin drive of the
//   LED fade dimmer into one interface.
//
//   Signals:
//     led_in      [LED_NUM]   on/off request per LED (upstream indicator stage)
//     brightness  [PWM_BITS]  "on" duty shared by all LEDs
//     led_out     [LED_NUM]   PWM drive to LED pins, active-high
//
//   Modports:
//     master : upstream side, drives led_in/brightness and observes led_out
//     slave  : dimmer side, consumes led_in/brightness and drives led_out
// -----------------------------------------------------------------------------
interface led_fade_if #(
   parameter int LED_NUM  = 4,
   parameter int PWM_BITS = 8
);
   logic [LED_NUM-1:0]  led_in;
   logic [PWM_BITS-1:0] brightness;
   logic [LED_NUM-1:0]  led_out;

   modport master (output led_in, output brightness, input led_out);
   modport slave  (input led_in, input brightness, output led_out);
endinterface

// File: rtl/led_fade_pwm.sv
// -----------------------------------------------------------------------------
// led_fade_pwm
//   PWM dimmer for the LED indicator outputs. Each channel keeps a duty level
//   that steps one LSB per fade tick toward its target (brightness when the
//   LED is requested on, zero when off), so on/off transitions fade instead of
//   snapping. The level is copied into a shadow duty register once per PWM
//   period, and the pin is driven high while the shared PWM counter is below
//   that shadow duty.
//
//   Ports:
//     clk  : system clock
//     rst  : asynchronous reset, active-high; release is expected to be
//            synchronised to clk by the reset source
//     bus  : led_fade_if.slave carrying led_in, brightness (in), led_out (out)
//
//   Parameters:
//     LED_NUM  : number of LED channels
//     PWM_BITS : PWM counter/duty width, period = 2^PWM_BITS clk cycles
//     FADE_DIV : clk cycles per fade step (>= 1)
//
//   Build option:
//     LED_FADE_GAMMA_EN : when defined, the shadow duty is (level^2) >> PWM_BITS
//                         (square-law perceptual correction) instead of level.
// -----------------------------------------------------------------------------
module led_fade_pwm #(
   parameter int LED_NUM  = 4,
   parameter int PWM_BITS = 8,
   parameter int FADE_DIV = 50_000
) (
   input  logic      clk,
   input  logic      rst,
   led_fade_if.slave bus
);

   localparam int                  TICK_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(FADE_DIV - 1);
   localparam logic [PWM_BITS-1:0] PWM_LAST  = '1;

   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_BITS-1:0] level_q       [LED_NUM];
   logic [PWM_BITS-1:0] level_d       [LED_NUM];
   logic [PWM_BITS-1:0] active_duty_q [LED_NUM];
   logic [PWM_BITS-1:0] active_duty_d [LED_NUM];
   logic [LED_NUM-1:0]  led_out_q, led_out_d;
   logic                tick;
   logic                wrap;

   // One LSB toward the target; equal holds, so the level can neither
   // overshoot nor wrap.
   function automatic logic [PWM_BITS-1:0] step_level(
      input logic [PWM_BITS-1:0] cur,
      input logic [PWM_BITS-1:0] tgt
   );
      if (cur < tgt) begin
         return cur + PWM_BITS'(1);
      end else if (cur > tgt) begin
         return cur - PWM_BITS'(1);
      end else begin
         return cur;
      end
   endfunction

   // Maps a fade level to the duty used for the next PWM period.
   function automatic logic [PWM_BITS-1:0] shape_duty(input logic [PWM_BITS-1:0] lvl);
`ifdef LED_FADE_GAMMA_EN
      logic [2*PWM_BITS-1:0] sq;
      sq = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
      return sq[2*PWM_BITS-1:PWM_BITS];
`else
      return lvl;
`endif
   endfunction

   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      wrap       = (pwm_cnt_q == PWM_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
      pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
      led_out_d  = '0;
      for (int i = 0; i < LED_NUM; i++) begin
         level_d[i]       = level_q[i];
         active_duty_d[i] = active_duty_q[i];
         if (tick) begin
            level_d[i] = step_level(level_q[i], bus.led_in[i] ? bus.brightness : '0);
         end
         // Shadow copy uses the registered level, so a tick landing on the
         // wrap cycle is seen only in the following period.
         if (wrap) begin
            active_duty_d[i] = shape_duty(level_q[i]);
         end
         led_out_d[i] = (pwm_cnt_q < active_duty_q[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q <= '0;
         pwm_cnt_q  <= '0;
         led_out_q  <= '0;
         for (int i = 0; i < LED_NUM; i++) begin
            level_q[i]       <= '0;
            active_duty_q[i] <= '0;
         end
      end else begin
         tick_cnt_q <= tick_cnt_d;
         pwm_cnt_q  <= pwm_cnt_d;
         led_out_q  <= led_out_d;
         for (int i = 0; i < LED_NUM; i++) begin
            level_q[i]       <= level_d[i];
            active_duty_q[i] <= active_duty_d[i];
         end
      end
   end

   assign bus.led_out = led_out_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// -----------------------------------------------------------------------------
// tb_led_fade_pwm
//   Directed bench for led_fade_pwm with PWM_BITS=4, LED_NUM=4. dut_a uses
//   FADE_DIV=2; dut_b uses FADE_DIV=16 so its fade tick lands on the PWM wrap.
//   Cycle numbering: after reset release, cycle c is sampled at the c-th
//   falling clock edge; PWM count in cycle c is c mod 16.
// -----------------------------------------------------------------------------
module tb_led_fade_pwm;

   localparam int HN = 1024;

   typedef struct packed {
      logic [3:0]      li;
      logic [3:0]      br;
      logic [3:0][3:0] d_lin;   // {ch3, ch2, ch1, ch0}
      logic [3:0][3:0] d_gam;
   } vec_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   int   cyc;
   logic [3:0] hist_a [HN];
   logic [3:0] hist_b [HN];
   vec_t vecs [5];

   led_fade_if #(.LED_NUM(4), .PWM_BITS(4)) bus_a ();
   led_fade_if #(.LED_NUM(4), .PWM_BITS(4)) bus_b ();

   led_fade_pwm #(.LED_NUM(4), .PWM_BITS(4), .FADE_DIV(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   led_fade_pwm #(.LED_NUM(4), .PWM_BITS(4), .FADE_DIV(16)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Linear-build value vs gamma-build value of a hand-computed duty.
   function automatic int dsel(input int lin, input int gam);
`ifdef LED_FADE_GAMMA_EN
      return gam;
`else
      return lin;
`endif
   endfunction

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cyc++;
         if (cyc < HN) begin
            hist_a[cyc] = bus_a.led_out;
            hist_b[cyc] = bus_b.led_out;
         end
      end
   endtask

   task automatic run_to(input int c);
      if (c > cyc) step(c - cyc);
   endtask

   function automatic int win_a(input int ch, input int start);
      int s = 0;
      for (int c = start; c < start + 16; c++) s += int'(hist_a[c][ch]);
      return s;
   endfunction

   function automatic int win_b(input int ch, input int start);
      int s = 0;
      for (int c = start; c < start + 16; c++) s += int'(hist_b[c][ch]);
      return s;
   endfunction

   // Reset with led_in=F / brightness=15 held, then release with li/br applied.
   task automatic do_reset(input logic [3:0] li, input logic [3:0] br, input string tag);
      @(negedge clk);
      bus_a.led_in = 4'hF;  bus_a.brightness = 4'd15;
      bus_b.led_in = 4'hF;  bus_b.brightness = 4'd15;
      #2 rst = 1'b1;
      #1 chk({tag, " led_out_async"}, int'(bus_a.led_out), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk({tag, " led_out_in_rst"}, int'(bus_a.led_out), 0);
         chk({tag, " level0_in_rst"}, int'(dut_a.level_q[0]), 0);
      end
      bus_a.led_in = li;  bus_a.brightness = br;
      bus_b.led_in = li;  bus_b.brightness = br;
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      logic [3:0] ev;
      int         ored;
      n_cmp = 0;
      n_bad = 0;
      cyc   = 0;
      rst   = 1'b1;
      bus_a.led_in = '0;  bus_a.brightness = '0;
      bus_b.led_in = '0;  bus_b.brightness = '0;

      vecs[0] = '{li: 4'b0001, br: 4'd8,  d_lin: {4'd0, 4'd0, 4'd0, 4'd8},
                  d_gam: {4'd0, 4'd0, 4'd0, 4'd4}};
      vecs[1] = '{li: 4'b1111, br: 4'd15, d_lin: {4'd15, 4'd15, 4'd15, 4'd15},
                  d_gam: {4'd14, 4'd14, 4'd14, 4'd14}};
      vecs[2] = '{li: 4'b1010, br: 4'd3,  d_lin: {4'd3, 4'd0, 4'd3, 4'd0},
                  d_gam: {4'd0, 4'd0, 4'd0, 4'd0}};
      vecs[3] = '{li: 4'b0110, br: 4'd0,  d_lin: {4'd0, 4'd0, 4'd0, 4'd0},
                  d_gam: {4'd0, 4'd0, 4'd0, 4'd0}};
      vecs[4] = '{li: 4'b1001, br: 4'd12, d_lin: {4'd12, 4'd0, 4'd0, 4'd12},
                  d_gam: {4'd9, 4'd0, 4'd0, 4'd9}};

      // Ramp up on channel 0 only.
      do_reset(4'b0001, 4'd15, "por");
      run_to(1);  chk("ramp lvl0@1", int'(dut_a.level_q[0]), 0);
      run_to(2);  chk("ramp lvl0@2", int'(dut_a.level_q[0]), 1);
                  chk("ramp lvl1@2", int'(dut_a.level_q[1]), 0);
      run_to(29); chk("ramp lvl0@29", int'(dut_a.level_q[0]), 14);
      run_to(30); chk("ramp lvl0@30", int'(dut_a.level_q[0]), 15);
      run_to(64); chk("ramp lvl0@64", int'(dut_a.level_q[0]), 15);
      chk("ramp win1",  win_a(0, 1),  0);
      chk("ramp win17", win_a(0, 17), dsel(7, 3));
      chk("ramp win33", win_a(0, 33), dsel(15, 14));
      chk("ramp win49", win_a(0, 49), dsel(15, 14));
      ored = 0;
      for (int c = 1; c <= 64; c++) ored |= int'(hist_a[c][3:1]);
      chk("ramp ch3:1 idle", ored, 0);

      // Fade down from level 8.
      do_reset(4'b0001, 4'd8, "fade");
      run_to(16); chk("fade lvl0@16", int'(dut_a.level_q[0]), 8);
      run_to(40); bus_a.led_in = 4'b0000;
      run_to(42); chk("fade lvl0@42", int'(dut_a.level_q[0]), 7);
      run_to(55); chk("fade lvl0@55", int'(dut_a.level_q[0]), 1);
      run_to(56); chk("fade lvl0@56", int'(dut_a.level_q[0]), 0);
      run_to(96); chk("fade lvl0@96", int'(dut_a.level_q[0]), 0);
      chk("fade win33", win_a(0, 33), dsel(8, 4));
      chk("fade win49", win_a(0, 49), dsel(5, 1));
      chk("fade win65", win_a(0, 65), 0);
      chk("fade win81", win_a(0, 81), 0);
      chk("fade hi@49", int'(hist_a[49][0]), 1);
      chk("fade lo@54", int'(hist_a[54][0]), 0);

      // Steady duty table: settled window 49..64 must match cycle by cycle.
      for (int v = 0; v < 5; v++) begin
         do_reset(vecs[v].li, vecs[v].br, $sformatf("vec%0d", v));
         run_to(64);
         for (int c = 49; c <= 64; c++) begin
            for (int i = 0; i < 4; i++) begin
               ev[i] = ((c - 49) < dsel(int'(vecs[v].d_lin[i]), int'(vecs[v].d_gam[i])));
            end
            chk($sformatf("vec%0d out@%0d", v, c), int'(hist_a[c]), int'(ev));
         end
      end

      // Reset mid-ramp: async clear, restart from level 0 and pwm_cnt 0.
      do_reset(4'hF, 4'd15, "mid0");
      run_to(40); chk("mid out@40", int'(bus_a.led_out), 15);
      do_reset(4'hF, 4'd15, "mid1");
      run_to(1);
      for (int i = 0; i < 4; i++) chk($sformatf("mid lvl%0d@1", i), int'(dut_a.level_q[i]), 0);
      run_to(2);
      for (int i = 0; i < 4; i++) chk($sformatf("mid lvl%0d@2", i), int'(dut_a.level_q[i]), 1);
      run_to(32);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("mid win1 ch%0d", i),  win_a(i, 1),  0);
         chk($sformatf("mid win17 ch%0d", i), win_a(i, 17), dsel(7, 3));
      end

      // Tick coincident with wrap (FADE_DIV=16): pre-tick level is latched.
      do_reset(4'b0001, 4'd15, "bnd");
      run_to(15);  chk("bnd lvl@15", int'(dut_b.level_q[0]), 0);
      run_to(16);  chk("bnd lvl@16", int'(dut_b.level_q[0]), 1);
      run_to(64);
      chk("bnd win17", win_b(0, 17), 0);
      chk("bnd win33", win_b(0, 33), dsel(1, 0));
      chk("bnd win49", win_b(0, 49), dsel(2, 0));
      run_to(260); chk("bnd lvl@260", int'(dut_b.level_q[0]), 15);
      bus_b.brightness = 4'd4;
      run_to(272); chk("bnd lvl@272", int'(dut_b.level_q[0]), 14);
      run_to(431); chk("bnd lvl@431", int'(dut_b.level_q[0]), 5);
      run_to(432); chk("bnd lvl@432", int'(dut_b.level_q[0]), 4);
      run_to(600); chk("bnd lvl@600", int'(dut_b.level_q[0]), 4);
      chk("bnd win449", win_b(0, 449), dsel(4, 1));
      chk("bnd win561", win_b(0, 561), dsel(4, 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
